imm_decode_stage: RTL and testbench

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

---
 rtl/imm_decode_stage.sv | 136 +++++++++++++
 tb/tb_imm_decode_stage.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
// RISC-V immediate decode into a 2-entry output buffer. Latency is one cycle into an empty buffer.
// in_ready_out drops only when both entries are held. A stalled head entry keeps its payload stable.
module imm_decode_stage #(
  parameter int XLEN        = 32,
  parameter int AUTO_DECODE = 0,
  parameter int TAG_W       = 32
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             in_valid_in,
  output logic             in_ready_out,
  input  logic [31:0]      instr_in,
  input  logic [2:0]       imm_type_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid_out,
  input  logic             out_ready_in,
  output logic [XLEN-1:0]  imm_out,
  output logic [2:0]       imm_type_out,
  output logic             illegal_out,
  output logic [TAG_W-1:0] tag_out
);

  typedef enum logic [2:0] {
    IMM_R = 3'b000,
    IMM_I = 3'b001,
    IMM_S = 3'b010,
    IMM_B = 3'b011,
    IMM_U = 3'b100,
    IMM_J = 3'b101,
    IMM_L = 3'b110,
    IMM_Z = 3'b111
  } imm_type_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_type_e        typ;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  imm_type_e       dec_type;
  logic            dec_illegal;
  logic [31:0]     raw_imm;
  logic [XLEN-1:0] dec_imm;
  entry_t          wr_entry;
  entry_t          head;
  entry_t          mem [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      occ;
  logic            push;
  logic            pop;

  always_comb begin
    dec_type    = imm_type_e'(imm_type_in);
    dec_illegal = 1'b0;
    if (AUTO_DECODE != 0) begin
      case (instr_in[6:0])
        7'b0110011:             dec_type = IMM_R;
        7'b0010011, 7'b1100111: dec_type = IMM_I;
        7'b0000011:             dec_type = IMM_L;
        7'b0100011:             dec_type = IMM_S;
        7'b1100011:             dec_type = IMM_B;
        7'b0110111, 7'b0010111: dec_type = IMM_U;
        7'b1101111:             dec_type = IMM_J;
        // SYSTEM: funct3[2] selects the immediate-operand CSR forms
        7'b1110011:             dec_type = instr_in[14] ? IMM_Z : IMM_I;
        default: begin
          dec_type    = IMM_R;
          dec_illegal = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    raw_imm = 32'h0;
    case (dec_type)
      IMM_I, IMM_L: raw_imm = {{20{instr_in[31]}}, instr_in[31:20]};
      IMM_S:        raw_imm = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
      IMM_B:        raw_imm = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                               instr_in[30:25], instr_in[11:8], 1'b0};
      IMM_U:        raw_imm = {instr_in[31:12], 12'h000};
      IMM_J:        raw_imm = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                               instr_in[20], instr_in[30:21], 1'b0};
      IMM_Z:        raw_imm = {27'h0, instr_in[19:15]};
      default:      raw_imm = 32'h0;
    endcase
  end

  // raw_imm[31] is already the sign for every signed type and 0 for Z and R.
  assign dec_imm = XLEN'($signed(raw_imm));

  always_comb begin
    wr_entry         = '0;
    wr_entry.imm     = dec_imm;
    wr_entry.typ     = dec_type;
    wr_entry.illegal = dec_illegal;
    wr_entry.tag     = tag_in;
  end

  assign in_ready_out  = (occ < 2'd2);
  assign out_valid_out = (occ != 2'd0);
  assign push          = in_valid_in && in_ready_out;
  assign pop           = out_valid_out && out_ready_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign head         = mem[rd_ptr];
  assign imm_out      = head.imm;
  assign imm_type_out = head.typ;
  assign illegal_out  = head.illegal;
  assign tag_out      = head.tag;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: three configurations share one stimulus stream and one queue model.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr = 32'h0;
  logic [2:0]  imm_type = 3'b000;
  logic [31:0] tag = 32'h0;

  logic        o_rdy [3];
  logic        o_vld [3];
  logic        o_ill [3];
  logic [2:0]  o_typ [3];
  logic [31:0] o_tag [3];
  logic [63:0] o_imm [3];
  logic [31:0] imm_a, imm_m;
  logic [63:0] imm_w;

  assign o_imm[0] = {32'h0, imm_a};
  assign o_imm[1] = imm_w;
  assign o_imm[2] = {32'h0, imm_m};

  typedef struct {
    logic [31:0] ins;
    logic [2:0]  typ;
    logic [31:0] tag;
  } txn_t;

  txn_t mq[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .AUTO_DECODE(1), .TAG_W(32)) dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .in_valid_in(in_valid), .in_ready_out(o_rdy[0]),
    .instr_in(instr), .imm_type_in(imm_type), .tag_in(tag), .out_valid_out(o_vld[0]),
    .out_ready_in(out_ready), .imm_out(imm_a), .imm_type_out(o_typ[0]),
    .illegal_out(o_ill[0]), .tag_out(o_tag[0]));

  imm_decode_stage #(.XLEN(64), .AUTO_DECODE(1), .TAG_W(32)) dut_w (
    .clk_in(clk), .rst_n_in(rst_n), .in_valid_in(in_valid), .in_ready_out(o_rdy[1]),
    .instr_in(instr), .imm_type_in(imm_type), .tag_in(tag), .out_valid_out(o_vld[1]),
    .out_ready_in(out_ready), .imm_out(imm_w), .imm_type_out(o_typ[1]),
    .illegal_out(o_ill[1]), .tag_out(o_tag[1]));

  imm_decode_stage #(.XLEN(32), .AUTO_DECODE(0), .TAG_W(32)) dut_m (
    .clk_in(clk), .rst_n_in(rst_n), .in_valid_in(in_valid), .in_ready_out(o_rdy[2]),
    .instr_in(instr), .imm_type_in(imm_type), .tag_in(tag), .out_valid_out(o_vld[2]),
    .out_ready_in(out_ready), .imm_out(imm_m), .imm_type_out(o_typ[2]),
    .illegal_out(o_ill[2]), .tag_out(o_tag[2]));

  function automatic logic [2:0] ref_type(input logic [31:0] ins, input bit auto,
                                          input logic [2:0] tin);
    if (!auto) return tin;
    case (ins[6:0])
      7'b0010011, 7'b1100111: return 3'b001;
      7'b0000011:             return 3'b110;
      7'b0100011:             return 3'b010;
      7'b1100011:             return 3'b011;
      7'b0110111, 7'b0010111: return 3'b100;
      7'b1101111:             return 3'b101;
      7'b1110011:             return (ins[14] == 1'b1) ? 3'b111 : 3'b001;
      default:                return 3'b000;
    endcase
  endfunction

  function automatic bit ref_illegal(input logic [31:0] ins, input bit auto);
    return auto && !(ins[6:0] inside {7'b0110011, 7'b0010011, 7'b1100111, 7'b0000011,
                                      7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                                      7'b1101111, 7'b1110011});
  endfunction

  // Immediate as a signed integer value, then truncated to the output width.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] t,
                                          input int xlen);
    longint v;
    case (t)
      3'b001, 3'b110: v = longint'($signed(ins[31:20]));
      3'b010:         v = longint'($signed({ins[31:25], ins[11:7]}));
      3'b011:         v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) * 2;
      3'b100:         v = longint'($signed(ins[31:12])) * 4096;
      3'b101:         v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) * 2;
      3'b111:         v = longint'(ins[19:15]);
      default:        v = 0;
    endcase
    if (xlen == 32) return {32'h0, v[31:0]};
    return 64'(v);
  endfunction

  task automatic tick();
    bit push, pop;
    push = in_valid && (mq.size() < 2);
    pop  = out_ready && (mq.size() > 0);
    @(posedge clk); #1;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back('{ins: instr, typ: imm_type, tag: tag});
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (o_vld[k] !== 1'b0) begin errors++; $display("FAIL reset_vld dut%0d got %b want 0", k, o_vld[k]); end
      checks++; if (o_rdy[k] !== 1'b1) begin errors++; $display("FAIL reset_rdy dut%0d got %b want 1", k, o_rdy[k]); end
      checks++; if (o_imm[k] !== 64'h0) begin errors++; $display("FAIL reset_imm dut%0d got %h want 0", k, o_imm[k]); end
      checks++; if (o_typ[k] !== 3'b000) begin errors++; $display("FAIL reset_typ dut%0d got %b want 000", k, o_typ[k]); end
      checks++; if (o_ill[k] !== 1'b0) begin errors++; $display("FAIL reset_ill dut%0d got %b want 0", k, o_ill[k]); end
      checks++; if (o_tag[k] !== 32'h0) begin errors++; $display("FAIL reset_tag dut%0d got %h want 0", k, o_tag[k]); end
    end
    rst_n = 1'b1;
    mq.delete();
  endtask

  task automatic test_spec_vectors();
    logic [31:0] vin  [6] = '{32'hFFF00093, 32'hFE000EE3, 32'h300FD073,
                              32'h800000B7, 32'h0000007F, 32'hFE000FA3};
    logic [2:0]  vtin [6] = '{3'b001, 3'b011, 3'b111, 3'b100, 3'b000, 3'b010};
    int          vdut [6] = '{0, 0, 0, 1, 0, 2};
    logic [63:0] vimm [6] = '{64'hFFFFFFFF, 64'hFFFFFFFC, 64'h1F,
                              64'hFFFFFFFF80000000, 64'h0, 64'hFFFFFFFF};
    logic [2:0]  vtyp [6] = '{3'b001, 3'b011, 3'b111, 3'b100, 3'b000, 3'b010};
    logic        vill [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      int d;
      d = vdut[i];
      in_valid = 1'b1; instr = vin[i]; imm_type = vtin[i]; tag = 32'h50 + i;
      tick();
      in_valid = 1'b0;
      checks++; if (o_vld[d] !== 1'b1) begin errors++; $display("FAIL vec%0d_vld got %b want 1", i, o_vld[d]); end
      checks++; if (o_imm[d] !== vimm[i]) begin errors++; $display("FAIL vec%0d_imm got %h want %h", i, o_imm[d], vimm[i]); end
      checks++; if (o_typ[d] !== vtyp[i]) begin errors++; $display("FAIL vec%0d_typ got %b want %b", i, o_typ[d], vtyp[i]); end
      checks++; if (o_ill[d] !== vill[i]) begin errors++; $display("FAIL vec%0d_ill got %b want %b", i, o_ill[d], vill[i]); end
      checks++; if (o_tag[d] !== 32'h50 + i) begin errors++; $display("FAIL vec%0d_tag got %h want %h", i, o_tag[d], 32'h50 + i); end
      tick();
      checks++; if (o_vld[d] !== 1'b0) begin errors++; $display("FAIL vec%0d_drain got %b want 0", i, o_vld[d]); end
    end
  endtask

  task automatic test_backpressure();
    int   got[$];
    bit   acc;
    out_ready = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      in_valid = 1'b1; tag = t; instr = $urandom(); imm_type = 3'($urandom_range(0, 7));
      checks++;
      if (o_rdy[0] !== ((t < 3) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL bp_rdy tag%0d got %b want %b", t, o_rdy[0], (t < 3));
      end
      if (t < 3) tick();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10 && got.size() < 3; c++) begin
      if (o_vld[0] === 1'b1) got.push_back(int'(o_tag[0]));
      acc = in_valid && o_rdy[0];
      tick();
      if (acc) in_valid = 1'b0;
    end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL bp_count got %0d want 3", got.size()); end
    for (int i = 0; i < got.size() && i < 3; i++) begin
      checks++; if (got[i] != i + 1) begin errors++; $display("FAIL bp_order idx%0d got %0d want %0d", i, got[i], i + 1); end
    end
    checks++; if (o_vld[0] !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", o_vld[0]); end
  endtask

  task automatic test_random();
    logic [6:0] ops [10] = '{7'b0110011, 7'b0010011, 7'b1100111, 7'b0000011, 7'b0100011,
                             7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011};
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (o_vld[k] !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_vld cyc%0d dut%0d got %b want %b", c, k, o_vld[k], (mq.size() > 0)); end
        checks++;
        if (o_rdy[k] !== (mq.size() < 2)) begin errors++; $display("FAIL rnd_rdy cyc%0d dut%0d got %b want %b", c, k, o_rdy[k], (mq.size() < 2)); end
        if (mq.size() > 0) begin
          logic [2:0]  et;
          logic [63:0] ei;
          bit          el;
          et = ref_type(mq[0].ins, k != 2, mq[0].typ);
          el = ref_illegal(mq[0].ins, k != 2);
          ei = ref_imm(mq[0].ins, et, (k == 1) ? 64 : 32);
          checks++;
          if (o_imm[k] !== ei) begin errors++; $display("FAIL rnd_imm cyc%0d dut%0d instr %h got %h want %h", c, k, mq[0].ins, o_imm[k], ei); end
          checks++;
          if (o_typ[k] !== et) begin errors++; $display("FAIL rnd_typ cyc%0d dut%0d instr %h got %b want %b", c, k, mq[0].ins, o_typ[k], et); end
          checks++;
          if (o_ill[k] !== el) begin errors++; $display("FAIL rnd_ill cyc%0d dut%0d instr %h got %b want %b", c, k, mq[0].ins, o_ill[k], el); end
          checks++;
          if (o_tag[k] !== mq[0].tag) begin errors++; $display("FAIL rnd_tag cyc%0d dut%0d got %h want %h", c, k, o_tag[k], mq[0].tag); end
        end
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      imm_type  = 3'($urandom_range(0, 7));
      tag       = $urandom();
      instr     = $urandom();
      if ($urandom_range(0, 3) != 0) instr[6:0] = ops[$urandom_range(0, 9)];
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; tag = 32'h100 + i; instr = $urandom(); imm_type = 3'($urandom_range(0, 7));
      checks++; if (o_rdy[1] !== 1'b1) begin errors++; $display("FAIL b2b_rdy idx%0d got %b want 1", i, o_rdy[1]); end
      tick();
      checks++; if (o_vld[1] !== 1'b1) begin errors++; $display("FAIL b2b_vld idx%0d got %b want 1", i, o_vld[1]); end
      checks++; if (o_tag[1] !== 32'h100 + i) begin errors++; $display("FAIL b2b_tag idx%0d got %h want %h", i, o_tag[1], 32'h100 + i); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (o_vld[1] !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", o_vld[1]); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; tag = 32'hA1 + i; instr = 32'hFFF00093; imm_type = 3'b001;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (o_rdy[0] !== 1'b0) begin errors++; $display("FAIL rstmid_full got %b want 0", o_rdy[0]); end
    #3 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (o_vld[k] !== 1'b0) begin errors++; $display("FAIL rstmid_vld dut%0d got %b want 0", k, o_vld[k]); end
      checks++; if (o_rdy[k] !== 1'b1) begin errors++; $display("FAIL rstmid_rdy dut%0d got %b want 1", k, o_rdy[k]); end
      checks++; if (o_tag[k] !== 32'h0) begin errors++; $display("FAIL rstmid_tag dut%0d got %h want 0", k, o_tag[k]); end
    end
    mq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; tag = 32'hB1; instr = 32'h800000B7; imm_type = 3'b100;
    tick();
    in_valid = 1'b0;
    checks++; if (o_tag[2] !== 32'hB1) begin errors++; $display("FAIL rstmid_first got %h want b1", o_tag[2]); end
    checks++; if (o_imm[1] !== 64'hFFFFFFFF80000000) begin errors++; $display("FAIL rstmid_imm got %h want ffffffff80000000", o_imm[1]); end
    tick();
    checks++; if (o_vld[2] !== 1'b0) begin errors++; $display("FAIL rstmid_stale got vld %b tag %h want 0", o_vld[2], o_tag[2]); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_spec_vectors();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
